// File: rtl/nn_weight_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nn_weight_mem_ctrl
// Description : Owner of the single-port weight RAM. Packs the host loader's
//               byte stream into RAM words and writes them. Also serves word
//               reads for the inference sequencer. The RAM performs one
//               operation per cycle. Reads normally win arbitration. A full
//               pack buffer that has waited STARVE_MAX cycles forces its write
//               through.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RST_N               clock, synchronous active-low reset
//   ld_start/ld_base/ld_nwords  load command (sampled in IDLE only)
//   ld_byte/ld_valid/ld_ready   weight byte stream
//   ld_busy, ld_done            load status (done is a 1-cycle pulse)
//   rd_req/rd_addr/rd_gnt       word read request and combinational grant
//   rd_valid/rd_data            read response, one cycle after the grant
//   err                         sticky illegal-address flag
//   mem_addr/mem_wdata/mem_we   RAM command
//   mem_rdata                   RAM registered read data
// ============================================================================
module nn_weight_mem_ctrl #(
    parameter int WWIDTH     = 8,
    parameter int WORD_W     = 256,
    parameter int ADDR_W     = 4,
    parameter int NUM_WORDS  = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    // host weight loader
    input  logic                ld_start,
    input  logic [ADDR_W-1:0]   ld_base,
    input  logic [ADDR_W:0]     ld_nwords,
    input  logic [WWIDTH-1:0]   ld_byte,
    input  logic                ld_valid,
    output logic                ld_ready,
    output logic                ld_busy,
    output logic                ld_done,
    // inference sequencer reads
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_gnt,
    output logic                rd_valid,
    output logic [WORD_W-1:0]   rd_data,
    output logic                err,
    // RAM
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                mem_we,
    input  logic [WORD_W-1:0]   mem_rdata
);

    localparam int WPW    = WORD_W / WWIDTH;
    localparam int BCNT_W = (WPW > 1) ? $clog2(WPW) : 1;
    localparam int ST_W   = $clog2(STARVE_MAX + 1);

    localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(WPW - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(1);
    localparam logic [ST_W-1:0]   STARVE_TOP = ST_W'(STARVE_MAX);
    localparam logic [ST_W-1:0]   STARVE_ONE = ST_W'(1);
    localparam logic [ADDR_W:0]   WORDS_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   WORDS_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    // One bit wider than an address so that NUM_WORDS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH      = (ADDR_W + 1)'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WPEND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [BCNT_W-1:0]   bcnt;
    logic [ADDR_W:0]     words;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ST_W-1:0]     starve;
    logic [WORD_W-1:0]   pack_buf;
    logic                err_q;
    logic                rd_valid_q;

    // Combinational decisions shared by the FSM and the datapath.
    logic                start_acc;
    logic                byte_acc;
    logic                wr_want;
    logic                wr_gnt;
    logic                wr_illegal;
    logic                rd_illegal;

    assign wr_illegal = ({1'b0, cur_addr} >= DEPTH);
    assign rd_illegal = ({1'b0, rd_addr}  >= DEPTH);
    assign mem_wdata  = pack_buf;
    assign rd_data    = mem_rdata;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, arbitration and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        byte_acc  = 1'b0;
        wr_want   = 1'b0;
        wr_gnt    = 1'b0;
        ld_ready  = 1'b0;
        ld_busy   = 1'b0;
        ld_done   = 1'b0;
        rd_gnt    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = rd_addr;
        rd_valid  = rd_valid_q;
        err       = err_q;

        wr_want = (state == WPEND);

        // A starved write beats any read; otherwise reads have priority.
        if (wr_want && (starve == STARVE_TOP)) begin
            wr_gnt = 1'b1;
        end else if (rd_req) begin
            rd_gnt = 1'b1;
        end else if (wr_want) begin
            wr_gnt = 1'b1;
        end

        if (wr_gnt) begin
            mem_addr = cur_addr;
            // An out-of-range write is dropped, but the load still advances.
            mem_we   = !wr_illegal;
        end

        case (state)
            IDLE: begin
                if (ld_start) begin
                    start_acc = 1'b1;
                    state_nxt = (ld_nwords == WORDS_ZERO) ? DONE : FILL;
                end
            end
            FILL: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (ld_valid) begin
                    byte_acc = 1'b1;
                    if (bcnt == BCNT_LAST) begin
                        state_nxt = WPEND;
                    end
                end
            end
            WPEND: begin
                ld_busy = 1'b1;
                if (wr_gnt) begin
                    state_nxt = (words == WORDS_ONE) ? DONE : FILL;
                end
            end
            DONE: begin
                ld_busy   = 1'b1;
                ld_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Everything visible is held quiet while reset is asserted, even
        // before the first reset edge has cleared the registers.
        if (!RST_N) begin
            start_acc = 1'b0;
            byte_acc  = 1'b0;
            wr_gnt    = 1'b0;
            ld_ready  = 1'b0;
            ld_busy   = 1'b0;
            ld_done   = 1'b0;
            rd_gnt    = 1'b0;
            mem_we    = 1'b0;
            rd_valid  = 1'b0;
            err       = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: pack buffer, counters, starvation tracking, read valid, error
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bcnt       <= '0;
            words      <= '0;
            cur_addr   <= '0;
            starve     <= '0;
            pack_buf   <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_gnt;

            if (start_acc) begin
                cur_addr <= ld_base;
                words    <= ld_nwords;
                bcnt     <= '0;
            end

            if (byte_acc) begin
                for (int k = 0; k < WPW; k++) begin
                    if (bcnt == BCNT_W'(k)) begin
                        pack_buf[k*WWIDTH +: WWIDTH] <= ld_byte;
                    end
                end
                bcnt <= (bcnt == BCNT_LAST) ? '0 : bcnt + BCNT_ONE;
            end

            if (wr_gnt) begin
                cur_addr <= cur_addr + ADDR_ONE;
                words    <= words - WORDS_ONE;
                starve   <= '0;
            end else if (wr_want && (starve != STARVE_TOP)) begin
                starve   <= starve + STARVE_ONE;
            end

            // Setting wins over the clear on a coincident start.
            if (start_acc) begin
                err_q <= 1'b0;
            end
            if ((wr_gnt && wr_illegal) || (rd_gnt && rd_illegal)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_weight_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_weight_mem_ctrl
// Description : Directed self-checking bench for nn_weight_mem_ctrl with a
//               small registered-read RAM model attached to the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_weight_mem_ctrl;

    localparam int WWIDTH = 8;
    localparam int WORD_W = 256;
    localparam int ADDR_W = 4;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                ld_start;
    logic [ADDR_W-1:0]   ld_base;
    logic [ADDR_W:0]     ld_nwords;
    logic [WWIDTH-1:0]   ld_byte;
    logic                ld_valid;
    logic                ld_ready;
    logic                ld_busy;
    logic                ld_done;
    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_gnt;
    logic                rd_valid;
    logic [WORD_W-1:0]   rd_data;
    logic                err;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                mem_we;
    logic [WORD_W-1:0]   mem_rdata;

    // RAM model backdoor preload
    logic                pre_we;
    logic [ADDR_W-1:0]   pre_addr;
    logic [WORD_W-1:0]   pre_data;
    logic [WORD_W-1:0]   ram [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    nn_weight_mem_ctrl dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_nwords (ld_nwords),
        .ld_byte   (ld_byte),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always @(posedge CLK) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_value(input string tag, input logic [WORD_W-1:0] act,
                               input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 4 units
    // after the edge, well clear of both clock edges.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    function automatic logic [WORD_W-1:0] pattern(input logic [7:0] first);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < WORD_W / WWIDTH; k++) begin
            w[k*WWIDTH +: WWIDTH] = first + 8'(k);
        end
        return w;
    endfunction

    task automatic issue_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] n);
        next_cycle();
        ld_start  = 1'b1;
        ld_base   = base;
        ld_nwords = n;
    endtask

    task automatic load_bytes(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_byte  = first + 8'(i);
            mid();
            check_value("ld_ready_fill", {255'd0, ld_ready}, 256'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0; ld_start = 1'b0; ld_base = '0; ld_nwords = '0;
        ld_byte = '0; ld_valid = 1'b0; rd_req = 1'b0; rd_addr = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset: outputs quiet even with a read request pending
        next_cycle();
        next_cycle();
        rd_req = 1'b1;
        mid();
        check_value("rst_ld_ready", {255'd0, ld_ready}, 256'd0);
        check_value("rst_ld_busy",  {255'd0, ld_busy},  256'd0);
        check_value("rst_ld_done",  {255'd0, ld_done},  256'd0);
        check_value("rst_rd_gnt",   {255'd0, rd_gnt},   256'd0);
        check_value("rst_mem_we",   {255'd0, mem_we},   256'd0);
        check_value("rst_err",      {255'd0, err},      256'd0);
        next_cycle();
        rd_req = 1'b0;
        RST_N  = 1'b1;
        mid();
        check_value("rst_rd_valid", {255'd0, rd_valid}, 256'd0);

        // T1: single word at address 0, bytes 0x00..0x1F
        issue_start(4'd0, 5'd1);
        mid();
        check_value("t1_busy_idle", {255'd0, ld_busy}, 256'd0);
        load_bytes(32, 8'h00);
        next_cycle();
        ld_valid = 1'b0;
        mid();
        check_value("t1_ready_wpend", {255'd0, ld_ready}, 256'd0);
        check_value("t1_we",     {255'd0, mem_we}, 256'd1);
        check_value("t1_addr",   {252'd0, mem_addr}, 256'd0);
        check_value("t1_byte0",  {248'd0, mem_wdata[7:0]}, 256'h00);
        check_value("t1_byte31", {248'd0, mem_wdata[255:248]}, 256'h1F);
        check_value("t1_word",   mem_wdata, pattern(8'h00));
        next_cycle();
        mid();
        check_value("t1_done",   {255'd0, ld_done}, 256'd1);
        check_value("t1_we_off", {255'd0, mem_we}, 256'd0);
        next_cycle();
        mid();
        check_value("t1_done_off", {255'd0, ld_done}, 256'd0);
        check_value("t1_busy_off", {255'd0, ld_busy}, 256'd0);

        // T2: reads starve a full buffer; write forced after 4 read grants
        issue_start(4'd2, 5'd1);
        load_bytes(32, 8'h40);
        next_cycle();
        ld_valid = 1'b0;
        rd_req   = 1'b1;
        rd_addr  = 4'd1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            mid();
            check_value("t2_rd_gnt",  {255'd0, rd_gnt}, 256'd1);
            check_value("t2_rd_we",   {255'd0, mem_we}, 256'd0);
            check_value("t2_rd_addr", {252'd0, mem_addr}, 256'd1);
            if (k > 0) check_value("t2_rd_valid", {255'd0, rd_valid}, 256'd1);
        end
        next_cycle();
        mid();
        check_value("t2_forced_gnt",  {255'd0, rd_gnt}, 256'd0);
        check_value("t2_forced_we",   {255'd0, mem_we}, 256'd1);
        check_value("t2_forced_addr", {252'd0, mem_addr}, 256'd2);
        check_value("t2_forced_data", mem_wdata, pattern(8'h40));
        check_value("t2_forced_rdv",  {255'd0, rd_valid}, 256'd1);
        next_cycle();
        mid();
        check_value("t2_regrant",  {255'd0, rd_gnt}, 256'd1);
        check_value("t2_rdv_gap",  {255'd0, rd_valid}, 256'd0);
        check_value("t2_done",     {255'd0, ld_done}, 256'd1);
        next_cycle();
        rd_req = 1'b0;
        mid();
        check_value("t2_done_off", {255'd0, ld_done}, 256'd0);

        // T3: base 3, two words; second address 4 is out of range
        issue_start(4'd3, 5'd2);
        load_bytes(32, 8'h60);
        next_cycle();
        ld_valid = 1'b0;
        mid();
        check_value("t3_we0",   {255'd0, mem_we}, 256'd1);
        check_value("t3_addr0", {252'd0, mem_addr}, 256'd3);
        check_value("t3_err0",  {255'd0, err}, 256'd0);
        load_bytes(32, 8'h80);
        next_cycle();
        ld_valid = 1'b0;
        mid();
        check_value("t3_we1",   {255'd0, mem_we}, 256'd0);
        check_value("t3_addr1", {252'd0, mem_addr}, 256'd4);
        next_cycle();
        mid();
        check_value("t3_err1",  {255'd0, err}, 256'd1);
        check_value("t3_done",  {255'd0, ld_done}, 256'd1);

        // T4: reset in the middle of a word discards it
        issue_start(4'd0, 5'd1);
        load_bytes(10, 8'hF0);
        next_cycle();
        ld_valid = 1'b0;
        RST_N    = 1'b0;
        mid();
        check_value("t4_ready", {255'd0, ld_ready}, 256'd0);
        check_value("t4_busy",  {255'd0, ld_busy},  256'd0);
        check_value("t4_err",   {255'd0, err},      256'd0);
        next_cycle();
        mid();
        check_value("t4_we",    {255'd0, mem_we},   256'd0);
        check_value("t4_done",  {255'd0, ld_done},  256'd0);
        next_cycle();
        RST_N = 1'b1;
        mid();
        check_value("t4_err_after", {255'd0, err}, 256'd0);
        issue_start(4'd1, 5'd1);
        load_bytes(32, 8'hC0);
        next_cycle();
        ld_valid = 1'b0;
        mid();
        check_value("t4_we_new",   {255'd0, mem_we}, 256'd1);
        check_value("t4_addr_new", {252'd0, mem_addr}, 256'd1);
        check_value("t4_word_new", mem_wdata, pattern(8'hC0));
        next_cycle();
        next_cycle();

        // T6: preloaded word read back one cycle after the grant
        next_cycle();
        pre_we   = 1'b1;
        pre_addr = 4'd0;
        pre_data = {32{8'hA5}};
        next_cycle();
        pre_we  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 4'd0;
        mid();
        check_value("t6_gnt",  {255'd0, rd_gnt}, 256'd1);
        check_value("t6_addr", {252'd0, mem_addr}, 256'd0);
        next_cycle();
        rd_req = 1'b0;
        mid();
        check_value("t6_valid", {255'd0, rd_valid}, 256'd1);
        check_value("t6_data",  rd_data, {32{8'hA5}});
        next_cycle();
        mid();
        check_value("t6_valid_off", {255'd0, rd_valid}, 256'd0);

        // Illegal read address sets err
        next_cycle();
        rd_req  = 1'b1;
        rd_addr = 4'd5;
        mid();
        check_value("ill_rd_gnt", {255'd0, rd_gnt}, 256'd1);
        next_cycle();
        rd_req = 1'b0;
        mid();
        check_value("ill_rd_err", {255'd0, err}, 256'd1);

        // T5: zero-word load; start also clears err
        issue_start(4'd0, 5'd0);
        mid();
        check_value("t5_we_start", {255'd0, mem_we}, 256'd0);
        next_cycle();
        ld_start = 1'b0;
        mid();
        check_value("t5_done",  {255'd0, ld_done}, 256'd1);
        check_value("t5_we",    {255'd0, mem_we},  256'd0);
        check_value("t5_ready", {255'd0, ld_ready}, 256'd0);
        check_value("t5_err",   {255'd0, err},     256'd0);
        next_cycle();
        mid();
        check_value("t5_done_off", {255'd0, ld_done}, 256'd0);
        check_value("t5_busy_off", {255'd0, ld_busy}, 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
